fib_lpm: RTL and testbench
==========================

# fib_lpm

Parametrised forwarding information base for the NDN router. Holds one valid-bit hash table per prefix length. Supports single-cycle insertion and a sequential longest-prefix-match lookup that probes from the requested length down to 1. It sits between the PIT (lookup requests for outgoing interests) and the incoming data path (insertions of announced prefixes), and replaces the fixed-size FIB with configurable prefix/hash widths and proper valid/ready handshakes.

## Interface
- PREFIX_W, 64: prefix width in bits, MSB-aligned; must equal 2**LEN_W
- LEN_W, 6: width of length fields; legal lengths 0..PREFIX_W-1
- HASH_W, 10: hash width; each length row holds 2**HASH_W valid bits
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high (one clock; reset is asynchronous and active-high)
- ins_valid  in  1  insert request
- ins_ready  out  1  insert accepted when high with ins_valid
- ins_prefix  in  PREFIX_W  prefix to insert
- ins_len  in  LEN_W  significant MSBs of ins_prefix
- ins_del  in  1  present only with FIB_DELETE_EN: 1 = clear entry instead of set
- lk_valid  in  1  lookup request
- lk_ready  out  1  lookup accepted when high with lk_valid
- lk_prefix  in  PREFIX_W  prefix to match
- lk_len  in  LEN_W  starting (longest) length
- res_valid  out  1  result available
- res_ready  in  1  result consumed when high with res_valid
- res_hit  out  1  a matching length was found
- res_len  out  LEN_W  matched length, 0 on miss
- res_prefix  out  PREFIX_W  lookup prefix masked to res_len
- res_probes  out  LEN_W  number of table probes performed

## Operation
- mask(p,L): keep the top L bits of p and zero the rest.
- hash(p,L): XOR of all HASH_W-bit chunks of mask(p,L), taken from the LSB (top chunk zero-padded), XOR L zero-extended. Purely combinational.
- Table: rows 1..PREFIX_W-1, each 2**HASH_W bits. Length 0 is never stored. Hash aliasing can produce false hits; this is accepted behaviour.
- FSM states:
  - IDLE: ins_ready=lk_ready=1.
  - PROBE: both readies low.
  - RESP: both readies low; res_valid=1.
- IDLE, insert accepted: set table[L][hash] (clear it if ins_del=1). Stay in IDLE. An insert with ins_len=0 is accepted and ignored.
- IDLE, lookup accepted: latch prefix and len into cur_len; clear the probe counter.
  - lk_len=0 → RESP with miss, probes 0.
  - Otherwise → PROBE.
- IDLE, both valid in the same cycle: insert wins. lk_ready is driven low that cycle.
- PROBE, one probe per cycle at cur_len; probes increments per probe.
  - Bit set → RESP, hit=1, len=cur_len.
  - Bit clear and cur_len=1 → RESP, hit=0, len=0.
  - Otherwise → cur_len-1.
- RESP: hold all res_* stable until res_ready. Then return to IDLE; res_valid drops the next cycle.
- Reset, including mid-lookup: state returns to IDLE, all table bits are cleared, and any in-flight lookup is discarded.
- Reset values: res_valid=0, res_hit=0, res_len=0, res_prefix=0, res_probes=0. ins_ready and lk_ready are 1 from the first cycle after rst deasserts.

## Timing
- Insert: written at the accepting edge. Back-to-back inserts are allowed every cycle. A lookup accepted the next cycle sees the new entry.
- Lookup latency, from accept edge to first res_valid cycle, is probes+1 cycles:
  - Hit at the starting length: res_valid in cycle 2.
  - Full miss from length L: L+1 cycles.
  - lk_len=0: 1 cycle.
- Throughput: one lookup in flight. The next lookup is accepted no earlier than the cycle after the res handshake.
- Table read during PROBE is combinational from registered cur_len and the latched prefix.

## Configuration
- FIB_DELETE_EN defined: ins_del port exists. ins_del=1 clears the addressed bit; a lookup after the delete misses that entry unless it aliases.
- FIB_DELETE_EN undefined: no ins_del port; insert always sets the bit. Entries are removed only by rst.

## Test plan
- Reset, then lookup prefix 0xAB00_0000_0000_0000, len 16 on an empty table → res_hit=0, res_len=0, res_probes=16; res_valid 17 cycles after accept.
- Insert 0xAB00_0000_0000_0000 len 8, then lookup 0xABCD_0000_0000_0000 len 16 → res_hit=1, res_len=8, res_prefix=0xAB00_0000_0000_0000, res_probes=9.
- Insert len 8 and len 12 entries of the same prefix, then lookup len 16 → res_len=12, res_probes=5; hold res_ready=0 for 4 cycles and confirm the outputs are stable with lk_ready low.
- ins_valid and lk_valid asserted together in IDLE → insert accepted, lk_ready=0 that cycle; lookup accepted the following cycle and sees the new entry.
- Assert rst during PROBE → res_valid=0 immediately, table cleared; a subsequent lookup of the previously inserted prefix misses.
- With FIB_DELETE_EN: insert len 8, delete it, then lookup len 8 → res_hit=0, res_probes=8.

Source files
------------

// File: rtl/fib_lpm.sv
// fib_lpm: forwarding information base with one valid-bit hash row per prefix length
// and a sequential longest-prefix-match lookup; FIB_DELETE_EN adds the ins_del port.
module fib_lpm #(
   parameter int PREFIX_W = 64,
   parameter int LEN_W    = 6,
   parameter int HASH_W   = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ins_valid,
   output logic                ins_ready,
   input  logic [PREFIX_W-1:0] ins_prefix,
   input  logic [LEN_W-1:0]    ins_len,
`ifdef FIB_DELETE_EN
   input  logic                ins_del,
`endif
   input  logic                lk_valid,
   output logic                lk_ready,
   input  logic [PREFIX_W-1:0] lk_prefix,
   input  logic [LEN_W-1:0]    lk_len,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                res_hit,
   output logic [LEN_W-1:0]    res_len,
   output logic [PREFIX_W-1:0] res_prefix,
   output logic [LEN_W-1:0]    res_probes
);
   localparam int NCH = (PREFIX_W + HASH_W - 1) / HASH_W;
   localparam int PW  = NCH * HASH_W;

   typedef enum logic [1:0] {IDLE, PROBE, RESP} state_t;

   function automatic logic [PREFIX_W-1:0] mask(input logic [PREFIX_W-1:0] p, input logic [LEN_W-1:0] l);
      return p & ~({PREFIX_W{1'b1}} >> l);
   endfunction

   function automatic logic [HASH_W-1:0] hash(input logic [PREFIX_W-1:0] p, input logic [LEN_W-1:0] l);
      logic [PW-1:0]     w;
      logic [HASH_W-1:0] h;
      w = PW'(mask(p, l));
      h = HASH_W'(l);
      for (int i = 0; i < NCH; i++) h = h ^ w[i*HASH_W +: HASH_W];
      return h;
   endfunction

   state_t              state, state_n;
   logic [PREFIX_W-1:0] pfx, pfx_n;
   logic [LEN_W-1:0]    cur_len, cur_n, probes, probes_n, len_n;
   logic                hit_n, probe_hit, set_val;
   logic [2**HASH_W-1:0] tbl [PREFIX_W];

`ifdef FIB_DELETE_EN
   assign set_val = !ins_del;
`else
   assign set_val = 1'b1;
`endif

   assign ins_ready  = state == IDLE;
   assign lk_ready   = state == IDLE && !ins_valid;
   assign res_valid  = state == RESP;
   assign res_prefix = mask(pfx, res_len);
   assign res_probes = probes;
   assign probe_hit  = tbl[cur_len][hash(pfx, cur_len)];

   // row 0 is never written, so it stays cleared and length 0 can never hit
   always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < PREFIX_W; i++) tbl[i] <= '0;
      else if (ins_valid && ins_ready && ins_len != '0) tbl[ins_len][hash(ins_prefix, ins_len)] <= set_val;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= IDLE;
         pfx     <= '0;
         cur_len <= '0;
         probes  <= '0;
         res_hit <= 1'b0;
         res_len <= '0;
      end else begin
         state   <= state_n;
         pfx     <= pfx_n;
         cur_len <= cur_n;
         probes  <= probes_n;
         res_hit <= hit_n;
         res_len <= len_n;
      end

   always_comb begin
      state_n  = state;
      pfx_n    = pfx;
      cur_n    = cur_len;
      probes_n = probes;
      hit_n    = res_hit;
      len_n    = res_len;
      unique case (state)
         IDLE: if (lk_valid && lk_ready) begin
            pfx_n    = lk_prefix;
            cur_n    = lk_len;
            probes_n = '0;
            hit_n    = 1'b0;
            len_n    = '0;
            state_n  = lk_len == '0 ? RESP : PROBE;
         end
         PROBE: begin
            probes_n = probes + 1'b1;
            hit_n    = probe_hit;
            len_n    = probe_hit ? cur_len : '0;
            state_n  = (probe_hit || cur_len == LEN_W'(1)) ? RESP : PROBE;
            cur_n    = (probe_hit || cur_len == LEN_W'(1)) ? cur_len : cur_len - 1'b1;
         end
         RESP: state_n = res_ready ? IDLE : RESP;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_fib_lpm.sv
// tb_fib_lpm: directed and randomized checks of fib_lpm against a key-set LPM reference model.
module tb_fib_lpm;
   logic        clk = 0, rst = 1;
   logic        ins_valid = 0, ins_del = 0, lk_valid = 0, res_ready = 0;
   logic        ins_ready, lk_ready, res_valid, res_hit;
   logic [63:0] ins_prefix = 0, lk_prefix = 0, res_prefix;
   logic [5:0]  ins_len = 0, lk_len = 0, res_len, res_probes;
   int          checks = 0, errors = 0;
   int          keys[$];
   logic [63:0] pool[$];

   fib_lpm dut (
      .clk(clk), .rst(rst),
      .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_prefix(ins_prefix), .ins_len(ins_len),
`ifdef FIB_DELETE_EN
      .ins_del(ins_del),
`endif
      .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_prefix(lk_prefix), .lk_len(lk_len),
      .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_len(res_len),
      .res_prefix(res_prefix), .res_probes(res_probes)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] tmask(input logic [63:0] p, input int l);
      return l == 0 ? 64'd0 : (p >> (64 - l)) << (64 - l);
   endfunction

   function automatic int mhash(input logic [63:0] p, input int l);
      logic [63:0] m;
      int h;
      m = tmask(p, l);
      h = l;
      for (int i = 0; i < 7; i++) h ^= int'((m >> (10 * i)) & 64'h3ff);
      return h;
   endfunction

   function automatic bit has_key(input int k);
      foreach (keys[i]) if (keys[i] == k) return 1;
      return 0;
   endfunction

   task automatic m_update(input logic [63:0] p, input int l, input bit del);
      int k;
      int q[$];
      if (l == 0) return;
      k = l * 1024 + mhash(p, l);
      if (!del) begin
         if (!has_key(k)) keys.push_back(k);
      end else begin
         foreach (keys[i]) if (keys[i] != k) q.push_back(keys[i]);
         keys = q;
      end
   endtask

   task automatic model_lookup(input logic [63:0] p, input int l, output int eh, output int el, output int ep);
      eh = 0; el = 0; ep = 0;
      for (int len = l; len >= 1; len--) begin
         ep++;
         if (has_key(len * 1024 + mhash(p, len))) begin
            eh = 1; el = len;
            break;
         end
      end
   endtask

   task automatic do_insert(input logic [63:0] p, input int l, input bit del);
      ins_valid = 1; ins_prefix = p; ins_len = 6'(l); ins_del = del;
      #1 chk("ins_ready", ins_ready, 1);
      @(posedge clk); #1 ins_valid = 0; ins_del = 0;
      m_update(p, l, del);
   endtask

   task automatic do_lookup(input logic [63:0] p, input int l, input int hold, input string tag);
      int eh, el, ep, cyc;
      model_lookup(p, l, eh, el, ep);
      lk_valid = 1; lk_prefix = p; lk_len = 6'(l);
      #1 chk($sformatf("%s_lk_ready", tag), lk_ready, 1);
      @(posedge clk); #1 lk_valid = 0;
      cyc = 1;
      while (!res_valid && cyc < 100) begin
         @(posedge clk); #1 cyc++;
      end
      chk($sformatf("%s_latency", tag), cyc, ep + 1);
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) begin
            @(posedge clk); #1;
         end
         chk($sformatf("%s_valid", tag), res_valid, 1);
         chk($sformatf("%s_hit", tag), res_hit, eh);
         chk($sformatf("%s_len", tag), res_len, el);
         chk($sformatf("%s_prefix", tag), res_prefix, tmask(p, el));
         chk($sformatf("%s_probes", tag), res_probes, ep);
         chk($sformatf("%s_busy", tag), {ins_ready, lk_ready}, 0);
      end
      res_ready = 1;
      @(posedge clk); #1 res_ready = 0;
      chk($sformatf("%s_drop", tag), res_valid, 0);
      chk($sformatf("%s_idle", tag), {ins_ready, lk_ready}, 2'b11);
   endtask

   initial begin
      logic [63:0] p;
      int l;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", res_valid, 0);
      chk("rst_hit", res_hit, 0);
      chk("rst_len", res_len, 0);
      chk("rst_prefix", res_prefix, 0);
      chk("rst_probes", res_probes, 0);
      rst = 0;
      #1 chk("rst_ready", {ins_ready, lk_ready}, 2'b11);

      do_lookup(64'hAB00_0000_0000_0000, 16, 0, "empty");
      chk("empty_probes_const", res_probes, 16);
      do_insert(64'hAB00_0000_0000_0000, 8, 0);
      do_lookup(64'hABCD_0000_0000_0000, 16, 0, "l8");
      do_insert(64'hABC0_0000_0000_0000, 12, 0);
      do_lookup(64'hABCD_0000_0000_0000, 16, 4, "l12");
      chk("l12_len_const", res_len, 12);
      do_lookup(64'hABCD_0000_0000_0000, 0, 1, "len0");
      do_insert(64'hFFFF_0000_0000_0000, 0, 0);

      p = 64'h1234_5600_0000_0000;
      ins_valid = 1; ins_prefix = p; ins_len = 24;
      lk_valid = 1; lk_prefix = p; lk_len = 24;
      #1 chk("simul_ins_ready", ins_ready, 1);
      chk("simul_lk_ready", lk_ready, 0);
      @(posedge clk); #1 ins_valid = 0;
      m_update(p, 24, 0);
      do_lookup(p, 24, 0, "simul");

      p = 64'h5500_0000_0000_0000;
      do_insert(p, 8, 0);
      lk_valid = 1; lk_prefix = p; lk_len = 40;
      @(posedge clk); #1 lk_valid = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1;
      #1 chk("midrst_valid", res_valid, 0);
      chk("midrst_probes", res_probes, 0);
      @(posedge clk); #1 rst = 0;
      keys.delete();
      #1 chk("midrst_ready", {ins_ready, lk_ready}, 2'b11);
      do_lookup(p, 8, 0, "post_rst");
      chk("post_rst_hit_const", res_hit, 0);

`ifdef FIB_DELETE_EN
      p = 64'h7700_0000_0000_0000;
      do_insert(p, 8, 0);
      do_lookup(p, 8, 0, "pre_del");
      do_insert(p, 8, 1);
      do_lookup(p, 8, 0, "del");
`endif

      for (int n = 0; n < 40; n++) begin
         if (pool.size() == 0 || $urandom_range(0, 2) == 0) begin
            p = {$urandom, $urandom};
            l = $urandom_range(0, 63);
            do_insert(p, l, 0);
            pool.push_back(p);
         end else begin
            p = {$urandom, $urandom};
            p = pool[$urandom_range(0, pool.size() - 1)] ^ (p >> $urandom_range(0, 63));
            do_lookup(p, $urandom_range(0, 63), $urandom_range(0, 2), "rnd");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
